// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, oversampling constant and the
// default parameter set used by both the TX and RX paths.
package uart_pkg;

    // Ticks per bit cell on the line (16x oversampling)
    localparam int OVERSAMPLE = 16;

    // Defaults for a 100 MHz clock at 9600 baud, 8N1
    localparam int DEF_DBITS    = 8;
    localparam int DEF_SB_TICK  = 16;
    localparam int DEF_BR_LIMIT = 651;
    localparam int DEF_BR_BITS  = 10;
    localparam int DEF_FIFO_EXP = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Bits needed to hold any value in 0..max_val (at least one bit)
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO with count-based full/empty flags.
// The head word is always visible on rd_data while empty is low.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DBITS    = DEF_DBITS,
    parameter int FIFO_EXP = DEF_FIFO_EXP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [DBITS-1:0] wr_data,
    input  logic             rd_en,
    output logic [DBITS-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 2 ** FIFO_EXP;

    logic [DBITS-1:0]    mem [DEPTH];
    logic [FIFO_EXP-1:0] wr_ptr;
    logic [FIFO_EXP-1:0] rd_ptr;
    logic [FIFO_EXP:0]   count;
    logic                do_wr;
    logic                do_rd;

    // A pop on an empty FIFO is ignored; a push while full only lands when
    // a pop frees the head slot in the same cycle.
    always_comb begin
        do_rd = rd_en && (count != '0);
        do_wr = wr_en && ((count != (FIFO_EXP+1)'(DEPTH)) || do_rd);
    end

    // Storage array, written at the tail; no reset needed on the data
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at 2^FIFO_EXP; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + FIFO_EXP'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + FIFO_EXP'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (FIFO_EXP+1)'(1);
                2'b01:   count <= count - (FIFO_EXP+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (FIFO_EXP+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: buffers words in a FIFO and serialises each one as
// start bit, DBITS data bits LSB-first, then a stop period, on tx.
//
// Handshake: wr_en is a one-cycle push strobe qualified only by tx_full
// (inverse ready). A push while tx_full is high is dropped without
// overwriting anything, unless the FSM pops in that same cycle. The FSM
// is the only consumer and pops the head word as it leaves IDLE.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DBITS    = DEF_DBITS,
    parameter int SB_TICK  = DEF_SB_TICK,
    parameter int BR_LIMIT = DEF_BR_LIMIT,
    parameter int BR_BITS  = DEF_BR_BITS,
    parameter int FIFO_EXP = DEF_FIFO_EXP
) (
    input  logic             clk_100MHz,
    input  logic             reset_btn_n,
    input  logic             wr_en,
    input  logic [DBITS-1:0] wr_data,
    output logic             tx_full,
    output logic             tx_empty,
    output logic             tx_busy,
    output logic             tx_done_tick,
    output logic             tx,
    output tx_state_t        fsm_state
);

    localparam int S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int S_W   = cnt_width(S_MAX - 1);
    localparam int N_W   = cnt_width(DBITS - 1);

    tx_state_t          state, state_next;
    logic [S_W-1:0]     s, s_next;
    logic [N_W-1:0]     n, n_next;
    logic [DBITS-1:0]   b, b_next;
    logic [BR_BITS-1:0] br_cnt;
    logic               tick;
    logic               fifo_rd;
    logic [DBITS-1:0]   fifo_rd_data;
    logic               tx_reg, tx_next;
    logic               done_reg, done_next;

    uart_fifo #(
        .DBITS    (DBITS),
        .FIFO_EXP (FIFO_EXP)
    ) u_fifo (
        .clk     (clk_100MHz),
        .rst_n   (reset_btn_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    // Baud divider, held at zero in IDLE so each frame starts tick-aligned
    always_ff @(posedge clk_100MHz or negedge reset_btn_n) begin
        if (!reset_btn_n) begin
            br_cnt <= '0;
        end else if (state == ST_IDLE) begin
            br_cnt <= '0;
        end else if (tick) begin
            br_cnt <= '0;
        end else begin
            br_cnt <= br_cnt + BR_BITS'(1);
        end
    end

    assign tick = (br_cnt == BR_BITS'(BR_LIMIT - 1));

    // State register plus datapath registers; tx and the done pulse are
    // registered so the pin never glitches
    always_ff @(posedge clk_100MHz or negedge reset_btn_n) begin
        if (!reset_btn_n) begin
            state    <= ST_IDLE;
            s        <= '0;
            n        <= '0;
            b        <= '0;
            tx_reg   <= 1'b1;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            s        <= s_next;
            n        <= n_next;
            b        <= b_next;
            tx_reg   <= tx_next;
            done_reg <= done_next;
        end
    end

    // Next-state logic: tick counter s paces each bit cell, n counts data bits
    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        fifo_rd    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!tx_empty) begin
                    fifo_rd    = 1'b1;
                    b_next     = fifo_rd_data;
                    s_next     = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s == S_W'(OVERSAMPLE - 1)) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = ST_DATA;
                    end else begin
                        s_next = s + S_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s == S_W'(OVERSAMPLE - 1)) begin
                        s_next = '0;
                        b_next = b >> 1;
                        if (n == N_W'(DBITS - 1)) begin
                            state_next = ST_STOP;
                        end else begin
                            n_next = n + N_W'(1);
                        end
                    end else begin
                        s_next = s + S_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (s == S_W'(SB_TICK - 1)) begin
                        state_next = ST_IDLE;
                    end else begin
                        s_next = s + S_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output logic: line level for the state being entered, and the done
    // pulse on the STOP -> IDLE transition
    always_comb begin
        tx_next   = 1'b1;
        done_next = (state == ST_STOP) && (state_next == ST_IDLE);
        case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = b_next[0];
            default:  tx_next = 1'b1;
        endcase
    end

    assign tx           = tx_reg;
    assign tx_done_tick = done_reg;
    assign tx_busy      = (state != ST_IDLE);
    assign fsm_state    = state;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine with a shortened baud divider (frame = 640
// clocks) plus a second instance with a 32-tick stop period.
module tb_uart_tx_engine;
    import uart_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    logic       reset_btn_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_full, tx_empty, tx_busy, tx_done_tick, tx;
    tx_state_t  fsm_state;

    logic       wr_en32;
    logic [7:0] wr_data32;
    logic       full32, empty32, busy32, done32, tx32;
    tx_state_t  fsm_state32;

    int cyc = 0;
    always @(posedge clk_100MHz) cyc <= cyc + 1;

    uart_tx_engine #(
        .DBITS(8), .SB_TICK(16), .BR_LIMIT(4), .BR_BITS(3), .FIFO_EXP(2)
    ) dut (
        .clk_100MHz   (clk_100MHz),
        .reset_btn_n  (reset_btn_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .tx_full      (tx_full),
        .tx_empty     (tx_empty),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .tx           (tx),
        .fsm_state    (fsm_state)
    );

    uart_tx_engine #(
        .DBITS(8), .SB_TICK(32), .BR_LIMIT(4), .BR_BITS(3), .FIFO_EXP(2)
    ) dut32 (
        .clk_100MHz   (clk_100MHz),
        .reset_btn_n  (reset_btn_n),
        .wr_en        (wr_en32),
        .wr_data      (wr_data32),
        .tx_full      (full32),
        .tx_empty     (empty32),
        .tx_busy      (busy32),
        .tx_done_tick (done32),
        .tx           (tx32),
        .fsm_state    (fsm_state32)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; the push is sampled at the next edge
    task automatic push(input logic [7:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) exp_q.push_back(d);
        @(posedge clk_100MHz); #1;
        wr_en = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk_100MHz); #1;
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            @(posedge clk_100MHz); #1;
            k++;
        end
        check("frames_done", done_cnt, target);
    endtask

    task automatic wait_done_edge(input int budget);
        int k;
        k = 0;
        while (!tx_done_tick && k < budget) begin
            @(posedge clk_100MHz); #1;
            k++;
        end
        check("done_seen", tx_done_tick, 1);
    endtask

    // ---------------- monitor: decodes the line, pops and compares ----------------
    bit         mon_active = 0;
    bit         have_prev  = 0;
    bit         done_prev  = 0;
    int         mon_cnt    = 0;
    int         start_cyc  = 0;
    logic [7:0] bits;

    always @(negedge clk_100MHz) begin
        if (!reset_btn_n) begin
            mon_active = 0;
            have_prev  = 0;
        end else begin
            if (tx_done_tick) begin
                done_cnt++;
                check("done_frame_len", cyc - start_cyc, 640);
                check("done_single_cycle", done_prev, 0);
                check("busy_low_at_done", tx_busy, 0);
            end
            if (!mon_active) begin
                if (tx == 1'b0) begin
                    if (have_prev && (cyc - start_cyc) < 650)
                        check("b2b_period", cyc - start_cyc, 641);
                    mon_active = 1;
                    mon_cnt    = 0;
                    start_cyc  = cyc;
                    have_prev  = 1;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt == 32)
                    check("start_bit", tx, 0);
                if (mon_cnt >= 96 && mon_cnt <= 544 && ((mon_cnt - 96) % 64) == 0)
                    bits[(mon_cnt - 96) / 64] = tx;
                if (mon_cnt == 608) begin
                    check("stop_bit", tx, 1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {24'd0, bits}, 32'hFFFF_FFFF);
                    end else begin
                        check("frame_data", {24'd0, bits}, {24'd0, exp_q.pop_front()});
                    end
                    mon_active = 0;
                end
            end
        end
        done_prev = tx_done_tick;
    end

    // ---------------- watchdog ----------------
    initial begin
        repeat (60000) @(posedge clk_100MHz);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int base, t0, k, off;
        logic stop_bad, last_bit;

        reset_btn_n = 1'b0;
        wr_en       = 1'b0;
        wr_data     = '0;
        wr_en32     = 1'b0;
        wr_data32   = '0;
        repeat (3) @(posedge clk_100MHz);
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done_tick, 0);
        check("rst_full", tx_full, 0);
        check("rst_empty", tx_empty, 1);
        check("rst_state", fsm_state, ST_IDLE);
        check("rst_state32", fsm_state32, ST_IDLE);
        reset_btn_n = 1'b1;
        idle(2);

        // Single word: 2-edge latency, then monitor checks bits and length
        push(8'hA5, 1);
        check("t1_empty_after_push", tx_empty, 0);
        check("t1_tx_still_high", tx, 1);
        idle(1);
        check("t1_tx_low", tx, 0);
        check("t1_busy", tx_busy, 1);
        wait_frames(1, 800);
        idle(1);
        check("t1_busy_after", tx_busy, 0);
        check("t1_tx_idle", tx, 1);
        check("t1_empty_after", tx_empty, 1);
        idle(20);

        // Three back-to-back frames
        base = done_cnt;
        push(8'h00, 1);
        push(8'hFF, 1);
        push(8'h3C, 1);
        wait_frames(base + 3, 2100);
        idle(20);

        // Overfill while first frame is in flight, then push on the pop edge
        base = done_cnt;
        push(8'h11, 1);
        check("t3_not_full_0", tx_full, 0);
        push(8'h22, 1);
        push(8'h33, 1);
        push(8'h44, 1);
        check("t3_not_full_3", tx_full, 0);
        push(8'h55, 1);
        check("t3_full", tx_full, 1);
        push(8'h66, 0);
        check("t3_full_after_drop", tx_full, 1);
        wait_done_edge(800);
        check("t4_full_at_done", tx_full, 1);
        push(8'h77, 1);
        check("t4_full_push_pop", tx_full, 1);
        check("t4_next_frame_started", tx, 0);
        idle(1);
        check("t4_full_hold", tx_full, 1);
        wait_frames(base + 6, 4000);
        check("t4_queue_drained", exp_q.size(), 0);
        check("t4_empty", tx_empty, 1);
        idle(20);

        // Reset in the middle of the data bits
        push(8'hC3, 1);
        push(8'h3C, 1);
        idle(200);
        check("t5_in_data", fsm_state, ST_DATA);
        #2;
        reset_btn_n = 1'b0;
        #1;
        check("t5_rst_tx", tx, 1);
        check("t5_rst_busy", tx_busy, 0);
        check("t5_rst_empty", tx_empty, 1);
        exp_q.delete();
        @(posedge clk_100MHz); #1;
        @(posedge clk_100MHz); #1;
        reset_btn_n = 1'b1;
        idle(3);
        base = done_cnt;
        push(8'h55, 1);
        wait_frames(base + 1, 800);
        check("t5_queue_drained", exp_q.size(), 0);
        idle(5);
        check("t5_no_extra_frame", done_cnt, base + 1);

        // 32-tick stop period: 128-clock stop, 704-clock frame
        wr_en32   = 1'b1;
        wr_data32 = 8'h5A;
        @(posedge clk_100MHz); #1;
        wr_en32 = 1'b0;
        check("sb32_empty", empty32, 0);
        @(posedge clk_100MHz); #1;
        check("sb32_start", tx32, 0);
        t0       = cyc;
        stop_bad = 1'b0;
        last_bit = 1'b1;
        k        = 0;
        while (!done32 && k < 2000) begin
            @(posedge clk_100MHz); #1;
            k++;
            off = cyc - t0;
            if (off >= 576 && off < 704 && tx32 !== 1'b1) stop_bad = 1'b1;
            if (off == 575) last_bit = tx32;
        end
        check("sb32_frame_len", cyc - t0, 704);
        check("sb32_stop_high", stop_bad, 0);
        check("sb32_last_data_bit", last_bit, 0);
        check("sb32_busy_low", busy32, 0);
        idle(1);
        check("sb32_done_single", done32, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Transmit half of the UART subsystem: accepts words from the debug/control logic through a write-enable interface, buffers them in a FIFO, and serialises each as an 8N1-style frame (start bit, DBITS data bits LSB-first, stop period) on `tx`. It is the transmit-side counterpart to the receive path that fills the RX FIFO. The block sits between the top-level control logic (`write_flag`/`write_data_reg` style producers) and the FPGA `tx` pin.

## Interface
- `DBITS`, 8, data bits per frame
- `SB_TICK`, 16, oversampling ticks in the stop period (16 = 1 stop bit)
- `BR_LIMIT`, 651, baud-tick divider (100 MHz / 651 ≈ 16 × 9600)
- `BR_BITS`, 10, baud counter width; must satisfy 2^BR_BITS ≥ BR_LIMIT
- `FIFO_EXP`, 8, FIFO depth = 2^FIFO_EXP words

- `clk_100MHz` in 1 — system clock
- `reset_btn_n` in 1 — asynchronous, active-low reset
- `wr_en` in 1 — push `wr_data` into FIFO this cycle
- `wr_data` in DBITS — word to transmit
- `tx_full` out 1 — FIFO full; pushes are dropped
- `tx_empty` out 1 — FIFO empty
- `tx_busy` out 1 — FSM not in IDLE
- `tx_done_tick` out 1 — one-cycle pulse at end of each frame's stop period
- `tx` out 1 — serial line, idle high, registered

## Operation
- Reset (async, `reset_btn_n` = 0): `tx`=1, `tx_busy`=0, `tx_done_tick`=0, `tx_full`=0, `tx_empty`=1; FIFO pointers/count cleared; FSM to IDLE; baud counter 0. Reset mid-frame aborts the frame immediately; `tx` returns high asynchronously.
- Baud generator: counter 0..BR_LIMIT-1, `tick` asserted for one cycle when count = BR_LIMIT-1, then wraps to 0. Counter held at 0 while FSM is IDLE, so every frame is tick-aligned to its start.
- FIFO: first-word-fall-through; count-based full/empty. Push when `wr_en` && !full; push while full is dropped silently (no overwrite). Pop only by FSM. Simultaneous push+pop when full: both succeed, stays full. Push+pop when empty: pop ignored, push succeeds. Pointers wrap modulo 2^FIFO_EXP.
- FSM (tick counter `s` 0..15, bit counter `n` 0..DBITS-1, shift register `b`):
  - IDLE: `tx`=1. If FIFO non-empty: pop, load `b`, `s`=0 → START.
  - START: `tx`=0. On tick: `s`=15 → `s`=0, `n`=0, DATA; else `s`++.
  - DATA: `tx`=`b[0]`. On tick with `s`=15: `s`=0, `b`>>=1; `n`=DBITS-1 → STOP else `n`++. Otherwise on tick `s`++.
  - STOP: `tx`=1. On tick with `s`=SB_TICK-1 → pulse `tx_done_tick`, IDLE; else on tick `s`++.
- Back-to-back frames: if FIFO non-empty on return to IDLE, next frame starts after exactly one IDLE cycle.

## Timing
- `wr_en` sampled at edge k → `tx_empty`=0 after edge k; FSM pops at edge k+1, `tx` low after edge k+1 (2-edge latency from idle).
- Start and each data bit: 16 × BR_LIMIT clocks. Stop: SB_TICK × BR_LIMIT clocks.
- Frame: (16·(1+DBITS)+SB_TICK)·BR_LIMIT clocks = 104 160 at defaults.
- `tx_done_tick` high for exactly one cycle, coincident with the transition to IDLE; `tx_busy` falls on the same edge.
- Frame period back-to-back: frame length + 1 clock.

## Structure
- Shared package `uart_pkg`: FSM state encoding (IDLE, START, DATA, STOP), oversample constant 16, default parameter values shared with the RX path.
- One sub-module: `uart_fifo` (parameterised DBITS/FIFO_EXP, FWFT, full/empty); reusable by the RX side. Baud generator and FSM stay inline.

## Test plan
Sim with BR_LIMIT=4, BR_BITS=3, FIFO_EXP=2 (frame = 640 clocks).
- Reset then single push 0xA5 → `tx` low 2 edges later; line bits 0,1,0,1,0,0,1,0,1,1 each 64 clocks; `tx_done_tick` one pulse at clock 640; `tx_busy` low after.
- Push 0x00, 0xFF, 0x3C back-to-back → three frames, 641-clock period, decoded bytes match in order, three `tx_done_tick` pulses.
- Push 6 words while first frame in flight → `tx_full`=1 after 4 buffered+1 in flight; extra pushes dropped; exactly 5 frames emitted.
- Push and FSM pop in same cycle when full → count unchanged, `tx_full` stays 1, no data corruption.
- Assert `reset_btn_n`=0 mid-DATA → `tx`=1 immediately, `tx_busy`=0, `tx_empty`=1; subsequent push 0x55 transmits a clean frame.
- SB_TICK=32 → stop period 128 clocks, frame 704 clocks.
